// File: rtl/bsg_id_pool.sv
// bsg_id_pool: pool of els_p IDs tracked by a registered free bitmask.
// Hands out the lowest free ID and takes IDs back by binary index.
module bsg_id_pool #(
    parameter  int els_p     = 16,
    localparam int lg_els_lp = $clog2(els_p),
    localparam int lg_cnt_lp = $clog2(els_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 alloc_v_o,
    output logic [lg_els_lp-1:0] alloc_id_o,
    input  logic                 alloc_yumi_i,
    input  logic                 dealloc_v_i,
    input  logic [lg_els_lp-1:0] dealloc_id_i,
    output logic [lg_cnt_lp-1:0] free_count_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 err_o
);

    localparam logic [els_p-1:0] one_lp = {{(els_p-1){1'b0}}, 1'b1};

    logic [els_p-1:0]     free_r;
    logic [lg_cnt_lp-1:0] count_r;
    logic                 err_r;

    logic [els_p-1:0]     alloc_oh;
    logic [els_p-1:0]     dealloc_oh;
    logic [els_p-1:0]     free_n;
    logic [lg_els_lp-1:0] alloc_id;
    logic                 yumi_ok;
    logic                 yumi_bad;
    logic                 dealloc_ok;
    logic                 dealloc_bad;

    always_comb begin
        alloc_id = '0;
        for (int i = els_p - 1; i >= 0; i--)
            if (free_r[i]) alloc_id = lg_els_lp'(i);
    end

    // Lowest set bit isolated arithmetically; matches alloc_id by construction.
    assign alloc_oh    = free_r & (~free_r + one_lp);
    // Out-of-range IDs shift the one off the top and decode to zero, so they
    // fail the allocated-bit test like a double free does.
    assign dealloc_oh  = one_lp << dealloc_id_i;

    assign yumi_ok     = alloc_yumi_i & (|free_r);
    assign yumi_bad    = alloc_yumi_i & ~(|free_r);
    assign dealloc_ok  = dealloc_v_i & (|(dealloc_oh & ~free_r));
    assign dealloc_bad = dealloc_v_i & ~dealloc_ok;

    assign free_n = (free_r & ~(yumi_ok ? alloc_oh : '0))
                  | (dealloc_ok ? dealloc_oh : '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            free_r  <= '1;
            count_r <= lg_cnt_lp'(els_p);
            err_r   <= 1'b0;
        end else begin
            free_r <= free_n;
            err_r  <= yumi_bad | dealloc_bad;
            case ({yumi_ok, dealloc_ok})
                2'b10:   count_r <= count_r - lg_cnt_lp'(1);
                2'b01:   count_r <= count_r + lg_cnt_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign alloc_v_o    = |free_r;
    assign alloc_id_o   = alloc_id;
    assign free_count_o = count_r;
    assign empty_o      = (count_r == '0);
    assign full_o       = (count_r == lg_cnt_lp'(els_p));
    assign err_o        = err_r;

endmodule

// File: tb/tb_bsg_id_pool.sv
// Scoreboard bench for bsg_id_pool: directed scenarios with hand expectations
// plus a reference mask model checked every cycle.
module tb_bsg_id_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, yumi, dv;
    logic [3:0] did;
    logic       av, empty, full, err;
    logic [3:0] aid;
    logic [4:0] cnt;

    bsg_id_pool #(.els_p(16)) dut (
        .clk_i(clk), .reset_i(reset), .alloc_v_o(av), .alloc_id_o(aid),
        .alloc_yumi_i(yumi), .dealloc_v_i(dv), .dealloc_id_i(did),
        .free_count_o(cnt), .empty_o(empty), .full_o(full), .err_o(err)
    );

    logic       reset12 = 1'b0, dv12 = 1'b0, yumi12 = 1'b0;
    logic [3:0] did12 = '0;
    logic       av12, empty12, full12, err12;
    logic [3:0] aid12;
    logic [3:0] cnt12;

    bsg_id_pool #(.els_p(12)) dut12 (
        .clk_i(clk), .reset_i(reset12), .alloc_v_o(av12), .alloc_id_o(aid12),
        .alloc_yumi_i(yumi12), .dealloc_v_i(dv12), .dealloc_id_i(did12),
        .free_count_o(cnt12), .empty_o(empty12), .full_o(full12), .err_o(err12)
    );

    typedef struct {
        logic       v;
        logic [3:0] id;
        logic [4:0] cnt;
        logic       empty;
        logic       full;
        logic       err;
    } snap_t;

    typedef struct {
        logic [3:0] cnt;
        logic       err;
    } s12_t;

    snap_t      model_q[$];
    snap_t      hand_q[$];
    logic [3:0] hs_q[$];
    s12_t       q12[$];

    int tests = 0;
    int fails = 0;

    logic [15:0] m_free = '1;
    int          m_cnt  = 16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_snap(input string tag, input snap_t s);
        chk({tag, "_alloc_v"}, 32'(av), 32'(s.v));
        chk({tag, "_alloc_id"}, 32'(aid), 32'(s.id));
        chk({tag, "_count"}, 32'(cnt), 32'(s.cnt));
        chk({tag, "_empty"}, 32'(empty), 32'(s.empty));
        chk({tag, "_full"}, 32'(full), 32'(s.full));
        chk({tag, "_err"}, 32'(err), 32'(s.err));
    endtask

    function automatic int lowest(input logic [15:0] f);
        for (int i = 0; i < 16; i++)
            if (f[i]) return i;
        return 0;
    endfunction

    // Monitor: compares whatever expectations are queued for the current cycle.
    always @(negedge clk) begin
        snap_t s;
        s12_t  t;
        if (model_q.size() > 0) begin
            s = model_q.pop_front();
            cmp_snap("model", s);
        end
        if (hand_q.size() > 0) begin
            s = hand_q.pop_front();
            cmp_snap("hand", s);
        end
        if (yumi && av && !reset) begin
            if (hs_q.size() == 0) chk("unexpected_handshake", 32'(1), 32'(0));
            else                  chk("handshake_id", 32'(aid), 32'(hs_q.pop_front()));
        end
        if (q12.size() > 0) begin
            t = q12.pop_front();
            chk("els12_count", 32'(cnt12), 32'(t.cnt));
            chk("els12_err", 32'(err12), 32'(t.err));
        end
    end

    // Drive one cycle of inputs, advance the model across the edge and queue
    // the outputs expected for the following cycle.
    task automatic cyc(input logic r, input logic y, input logic d, input int id);
        logic [15:0] nf;
        int          nc;
        logic        ne;
        reset = r; yumi = y; dv = d; did = id[3:0];
        nf = m_free; nc = m_cnt; ne = 1'b0;
        if (r) begin
            nf = '1; nc = 16;
        end else begin
            if (y && m_free != '0) begin
                hs_q.push_back(4'(lowest(m_free)));
                nf[lowest(m_free)] = 1'b0;
                nc--;
            end else if (y) begin
                ne = 1'b1;
            end
            if (d) begin
                if (id < 16 && !m_free[id]) begin
                    nf[id] = 1'b1;
                    nc++;
                end else begin
                    ne = 1'b1;
                end
            end
        end
        @(posedge clk);
        m_free = nf; m_cnt = nc;
        model_q.push_back('{v: (nf != '0), id: 4'(lowest(nf)), cnt: 5'(nc),
                            empty: (nc == 0), full: (nc == 16), err: ne});
        #1;
    endtask

    task automatic hand(input logic v, input int id, input int c, input logic e);
        hand_q.push_back('{v: v, id: 4'(id), cnt: 5'(c), empty: (c == 0),
                           full: (c == 16), err: e});
    endtask

    initial begin
        reset = 1'b0; yumi = 1'b0; dv = 1'b0; did = '0;

        // Allocate all 16 in order.
        cyc(1, 0, 0, 0); hand(1, 0, 16, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0);
            hand(i < 15, (i < 15) ? i + 1 : 0, 15 - i, 0);
        end

        // Return 9 then 3 to an empty pool.
        cyc(0, 0, 1, 9); hand(1, 9, 1, 0);
        cyc(0, 0, 1, 3); hand(1, 3, 2, 0);

        // Simultaneous alloc of 8 and dealloc of 2.
        cyc(1, 0, 0, 0); hand(1, 0, 16, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 2); hand(1, 2, 8, 0);
        cyc(0, 1, 0, 0); hand(1, 9, 7, 0);
        // Alloc 9 while double-freeing 9: alloc wins, dealloc flagged.
        cyc(0, 1, 1, 9); hand(1, 10, 6, 1);
        cyc(0, 0, 0, 0); hand(1, 10, 6, 0);

        // Double free on a full pool.
        cyc(1, 0, 0, 0); hand(1, 0, 16, 0);
        cyc(0, 0, 1, 5); hand(1, 0, 16, 1);
        cyc(0, 0, 0, 0); hand(1, 0, 16, 0);

        // Out-of-range dealloc on the 12-entry pool.
        reset12 = 1'b1; @(posedge clk); #1;
        q12.push_back('{cnt: 4'd12, err: 1'b0});
        reset12 = 1'b0; dv12 = 1'b1; did12 = 4'd13; @(posedge clk); #1;
        q12.push_back('{cnt: 4'd12, err: 1'b1});
        dv12 = 1'b0; @(posedge clk); #1;
        q12.push_back('{cnt: 4'd12, err: 1'b0});

        // Yumi on an empty pool.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0); hand(0, 0, 0, 1);
        cyc(0, 0, 0, 0); hand(0, 0, 0, 0);

        // Reset mid-stream with both handshakes active.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 2); hand(1, 0, 16, 0);

        // Random legal traffic.
        for (int n = 0; n < 10000; n++) begin
            logic y, d;
            int   id, start;
            y  = (m_free != '0) && ($urandom_range(0, 1) == 1);
            d  = 1'b0;
            id = 0;
            if (m_free != '1 && $urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++) begin
                    if (!d && !m_free[(start + k) % 16]) begin
                        d  = 1'b1;
                        id = (start + k) % 16;
                    end
                end
            end
            cyc(0, y, d, id);
        end

        cyc(0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("handshake_leftover", 32'(hs_q.size()), 32'(0));
        chk("model_leftover", 32'(model_q.size()), 32'(0));
        chk("hand_leftover", 32'(hand_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_id_pool.md
Name: bsg_id_pool

Overview:
- Tracks a pool of els_p IDs with a registered free bitmask.
- Allocation hands out the lowest-numbered free ID, found by a lo-to-hi priority encode of the mask.
- Deallocation takes a binary ID, decodes it to one-hot and returns it to the mask. This decode is the inverse direction of the priority encoder.
- Sits between a request issuer (tag, credit or MSHR ID allocation) and the returning response path.

Parameters:
- els_p, 16, number of IDs in the pool; legal range 2..64.
- lg_els_lp, $clog2(els_p), width of an ID (derived, not overridable).
- lg_cnt_lp, $clog2(els_p+1), width of the free count (derived).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous reset, active-high.
- alloc_v_o  out  1  at least one ID is free.
- alloc_id_o  out  lg_els_lp  lowest free ID; valid only when alloc_v_o=1.
- alloc_yumi_i  in  1  consumer takes alloc_id_o this cycle; legal only when alloc_v_o=1.
- dealloc_v_i  in  1  an ID is being returned this cycle.
- dealloc_id_i  in  lg_els_lp  ID being returned.
- free_count_o  out  lg_cnt_lp  number of free IDs.
- empty_o  out  1  all IDs allocated (free_count_o==0).
- full_o  out  1  all IDs free (free_count_o==els_p).
- err_o  out  1  one-cycle pulse reporting an illegal dealloc or yumi.

Behaviour:
- State registers: free_r[els_p-1:0], count_r, err_r.
- Reset (reset_i=1 at a clock edge):
  - free_r set to all ones; count_r set to els_p; err_r cleared.
  - One cycle after reset: alloc_v_o=1, alloc_id_o=0, full_o=1, empty_o=0, err_o=0.
  - Reset mid-operation discards all outstanding allocations.
  - reset_i has priority over every other input.
- Alloc outputs:
  - alloc_v_o = |free_r; alloc_id_o = index of the lowest set bit of free_r.
  - Both are driven from registered state only. There is no same-cycle bypass from dealloc_v_i; a returned ID becomes allocatable the next cycle.
  - When alloc_v_o=0, alloc_id_o is 0.
- Legal alloc: alloc_yumi_i=1 and alloc_v_o=1.
  - At the next edge, free_r[alloc_id_o] is cleared and count_r decrements by 1.
- Illegal yumi: alloc_yumi_i=1 while alloc_v_o=0.
  - Ignored: no state change, err_o pulses the next cycle.
- Legal dealloc: dealloc_v_i=1, dealloc_id_i<els_p, and free_r[dealloc_id_i]=0.
  - At the next edge, free_r[dealloc_id_i] is set and count_r increments by 1.
- Illegal dealloc (double free, or ID >= els_p when els_p is not a power of two):
  - Ignored: no state change, err_o pulses the next cycle.
- Simultaneous legal alloc and legal dealloc:
  - Both updates apply in the same cycle; count_r is unchanged.
  - The IDs always differ, because a legal dealloc targets an allocated ID and the alloc targets a free one.
- Simultaneous alloc with a double-free of alloc_id_o:
  - The alloc proceeds (bit cleared, count-1).
  - The dealloc is rejected and err_o pulses.
- Count arithmetic:
  - count_r never wraps; the legality checks guarantee 0 <= count_r <= els_p.
  - free_count_o = count_r; empty_o and full_o are decoded from count_r.
  - count_r must always equal popcount(free_r). Verification checks this invariant every cycle.
- err_o: registered, one cycle wide, the OR of all illegal conditions in the previous cycle.
- Latency:
  - Alloc handshake takes 0 cycles (ID presented and consumed in the same cycle).
  - Mask and count update 1 cycle after the handshake or dealloc.

Test Plan:
1. Reset, then alloc_yumi_i=1 for 16 consecutive cycles -> alloc_id_o sequence 0,1,...,15. After that, alloc_v_o=0, empty_o=1, free_count_o=0, err_o never asserted.
2. All 16 allocated; dealloc ID 9, next cycle dealloc ID 3 -> after the first: alloc_id_o=9, free_count_o=1. After the second: alloc_id_o=3, free_count_o=2.
3. IDs 0..7 allocated; same cycle alloc_yumi_i=1 (alloc_id_o=8) and dealloc ID 2 -> next cycle: alloc_id_o=2, free_count_o=8 (unchanged), bit 8 cleared, bit 2 set.
4. After reset, dealloc ID 5 (already free) -> free_count_o stays 16, err_o=1 for exactly one cycle. Separately, with els_p=12, dealloc ID 13 -> rejected, err_o pulses.
5. Pool empty, alloc_yumi_i=1 -> no state change, err_o pulse, free_count_o stays 0.
6. Allocate 5 IDs, assert reset_i for one cycle mid-stream while alloc_yumi_i=1 and dealloc_v_i=1 -> free_count_o=16, full_o=1, alloc_id_o=0, err_o=0.
7. Random stimulus of legal yumi/dealloc (10k cycles) against a scoreboard model -> alloc_id_o always equals the lowest free ID, and count equals popcount every cycle.
